// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: geometry, MixColumns mode encodings,
// column-collector FSM states and a byte-parity helper used when the
// AES_ARK_PARITY_EN build option is enabled.
package aes_pkg;

    localparam int AES_COL_W    = 32;
    localparam int AES_STATE_W  = 128;
    localparam int AES_NUM_COLS = 4;

    // Which MixColumns flavour a column arrives in; 2'd3 is reserved and
    // handled like MIX_RAW.
    localparam logic [1:0] MIX_FWD = 2'd0;
    localparam logic [1:0] MIX_INV = 2'd1;
    localparam logic [1:0] MIX_RAW = 2'd2;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } collect_state_t;

    // Bit i is the XOR of state byte i; bit 15 covers bits [127:120].
    function automatic logic [AES_STATE_W/8-1:0] byte_parity(input logic [AES_STATE_W-1:0] s);
        logic [AES_STATE_W/8-1:0] p;
        p = '0;
        for (int i = 0; i < AES_STATE_W / 8; i++) begin
            p[i] = ^s[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_ark_col_mux.sv
// One-column key add: picks the forward-mixed, inverse-mixed or unmixed
// column according to the mix mode and XORs it with the round-key word.
module aes_ark_col_mux
    import aes_pkg::*;
(
    input  logic [1:0]           mix_mode,
    input  logic [AES_COL_W-1:0] col_fwd,
    input  logic [AES_COL_W-1:0] col_inv,
    input  logic [AES_COL_W-1:0] col_raw,
    input  logic [AES_COL_W-1:0] rk_word,
    output logic [AES_COL_W-1:0] col_key
);

    logic [AES_COL_W-1:0] col_sel;

    // Column select (reserved mode falls through to the unmixed column) and key add
    always_comb begin
        col_sel = col_raw;
        case (mix_mode)
            MIX_FWD: col_sel = col_fwd;
            MIX_INV: col_sel = col_inv;
            default: col_sel = col_raw;
        endcase
        col_key = col_sel ^ rk_word;
    end

endmodule

// File: rtl/aes_ark_col_collect.sv
// Column-serial AddRoundKey and state assembler. Accepts one 32-bit column
// per handshake, adds the round-key word, and packs four columns into a
// registered 128-bit state handed downstream over valid/ready.
// Optional build macro: AES_ARK_PARITY_EN adds the state_par byte-parity port.
module aes_ark_col_collect
    import aes_pkg::*;
#(
    parameter int ROUND_W    = 4,
    parameter int LAST_ROUND = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   col_valid,
    output logic                   col_ready,
    input  logic [AES_COL_W-1:0]   col_fwd,
    input  logic [AES_COL_W-1:0]   col_inv,
    input  logic [AES_COL_W-1:0]   col_raw,
    input  logic [1:0]             mix_mode,
    input  logic [ROUND_W-1:0]     round_in,
    input  logic [AES_COL_W-1:0]   rk_word,
    output logic                   state_valid,
    input  logic                   state_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic [ROUND_W-1:0]     state_round,
    output logic                   state_last
`ifdef AES_ARK_PARITY_EN
    ,
    output logic [AES_STATE_W/8-1:0] state_par
`endif
);

    localparam logic [ROUND_W-1:0] LAST_TAG = LAST_ROUND[ROUND_W-1:0];

    collect_state_t               fsm;
    logic                         init_done;
    logic [1:0]                   col_cnt;
    logic [1:0]                   mode_q;
    logic [ROUND_W-1:0]           round_q;
    // Columns 0..2 of the state under construction; column 3 goes straight
    // into state_out together with these.
    logic [3*AES_COL_W-1:0]       work;
    logic [1:0]                   mode_eff;
    logic [AES_COL_W-1:0]         col_key;
    logic                         accept;

    // Column 0 uses the live mode; later columns reuse the mode latched with column 0
    assign mode_eff = (col_cnt == 2'd0) ? mix_mode : mode_q;

    // In FULL a new column 0 may enter only when the held state leaves the same cycle
    assign col_ready = init_done && ((fsm == COLLECT) || state_ready);
    assign accept    = col_valid && col_ready && !flush;

    aes_ark_col_mux u_col_mux (
        .mix_mode (mode_eff),
        .col_fwd  (col_fwd),
        .col_inv  (col_inv),
        .col_raw  (col_raw),
        .rk_word  (rk_word),
        .col_key  (col_key)
    );

    // Hold col_ready low until the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Column slotting, state hand-off FSM and output state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= COLLECT;
            col_cnt     <= 2'd0;
            mode_q      <= MIX_FWD;
            round_q     <= '0;
            work        <= '0;
            state_valid <= 1'b0;
            state_out   <= '0;
            state_round <= '0;
            state_last  <= 1'b0;
`ifdef AES_ARK_PARITY_EN
            state_par   <= '0;
`endif
        end else if (flush) begin
            fsm         <= COLLECT;
            col_cnt     <= 2'd0;
            work        <= '0;
            state_valid <= 1'b0;
        end else begin
            if (accept) begin
                col_cnt <= col_cnt + 2'd1;
                case (col_cnt)
                    2'd0: begin
                        work[3*AES_COL_W-1 -: AES_COL_W] <= col_key;
                        mode_q  <= mix_mode;
                        round_q <= round_in;
                    end
                    2'd1: work[2*AES_COL_W-1 -: AES_COL_W] <= col_key;
                    2'd2: work[AES_COL_W-1:0] <= col_key;
                    default: begin
                        state_out   <= {work, col_key};
                        state_round <= round_q;
                        state_last  <= (round_q == LAST_TAG);
`ifdef AES_ARK_PARITY_EN
                        state_par   <= byte_parity({work, col_key});
`endif
                    end
                endcase
            end

            case (fsm)
                COLLECT: begin
                    if (accept && (col_cnt == 2'd3)) begin
                        fsm         <= FULL;
                        state_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (state_ready) begin
                        fsm         <= COLLECT;
                        state_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm         <= COLLECT;
                    state_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ark_col_collect.sv
// Directed and randomized bench for aes_ark_col_collect. Expected states are
// built from the stimulus tables: pick the column form chosen by column 0's
// mode, XOR with the key word, concatenate column 0 first.
module tb_aes_ark_col_collect;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         col_valid;
    logic         col_ready;
    logic [31:0]  col_fwd;
    logic [31:0]  col_inv;
    logic [31:0]  col_raw;
    logic [1:0]   mix_mode;
    logic [3:0]   round_in;
    logic [31:0]  rk_word;
    logic         state_valid;
    logic         state_ready;
    logic [127:0] state_out;
    logic [3:0]   state_round;
    logic         state_last;
`ifdef AES_ARK_PARITY_EN
    logic [15:0]  state_par;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus table for the state being sent
    logic [31:0] mf [4];
    logic [31:0] mi [4];
    logic [31:0] mr [4];
    logic [31:0] mk [4];
    logic [1:0]  mm [4];
    logic [3:0]  mrd[4];

    aes_ark_col_collect #(.ROUND_W(4), .LAST_ROUND(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .col_fwd     (col_fwd),
        .col_inv     (col_inv),
        .col_raw     (col_raw),
        .mix_mode    (mix_mode),
        .round_in    (round_in),
        .rk_word     (rk_word),
        .state_valid (state_valid),
        .state_ready (state_ready),
        .state_out   (state_out),
        .state_round (state_round),
        .state_last  (state_last)
`ifdef AES_ARK_PARITY_EN
        ,
        .state_par   (state_par)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected state: column form chosen by column 0's mode, key-added, column 0 on top
    function automatic logic [127:0] model_state();
        logic [127:0] s;
        logic [31:0]  pick;
        s = '0;
        for (int j = 0; j < 4; j++) begin
            if (mm[0] == 2'd0)      pick = mf[j];
            else if (mm[0] == 2'd1) pick = mi[j];
            else                    pick = mr[j];
            s[127 - 32*j -: 32] = pick ^ mk[j];
        end
        return s;
    endfunction

    function automatic logic [15:0] model_par(input logic [127:0] s);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = ^s[8*i +: 8];
        return p;
    endfunction

    // Present one column and return just after the edge that accepts it
    task automatic send_col(input logic [31:0] f, input logic [31:0] i, input logic [31:0] r,
                            input logic [1:0] m, input logic [3:0] rd, input logic [31:0] k);
        int n;
        n = 0;
        col_fwd = f; col_inv = i; col_raw = r; mix_mode = m; round_in = rd; rk_word = k;
        col_valid = 1'b1;
        #1;
        while (!col_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL col_ready_timeout observed=%0d expected=<50", n);
        end
        @(posedge clk); #1;
        col_valid = 1'b0;
    endtask

    task automatic send_idx(input int j);
        send_col(mf[j], mi[j], mr[j], mm[j], mrd[j], mk[j]);
    endtask

    task automatic send_all(input string tag);
        for (int j = 0; j < 4; j++) begin
            send_idx(j);
            if (j == 2) chk({tag, "_valid_early"}, state_valid, 1'b0);
        end
    endtask

    task automatic check_state(input string tag);
        logic [127:0] e;
        e = model_state();
        chk({tag, "_valid"}, state_valid, 1'b1);
        chk({tag, "_out"},   state_out, e);
        chk({tag, "_round"}, state_round, mrd[0]);
        chk({tag, "_last"},  state_last, (mrd[0] == 4'd10));
`ifdef AES_ARK_PARITY_EN
        chk({tag, "_par"},   state_par, model_par(e));
`endif
    endtask

    task automatic take();
        state_ready = 1'b1;
        @(posedge clk); #1;
        state_ready = 1'b0;
        chk("take_valid_low", state_valid, 1'b0);
    endtask

    task automatic randomize_table();
        for (int j = 0; j < 4; j++) begin
            mf[j]  = $urandom; mi[j] = $urandom; mr[j] = $urandom; mk[j] = $urandom;
            mm[j]  = 2'($urandom_range(0, 3));
            mrd[j] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        logic [127:0] held;
        int           c0;
        int           stall;

        rst = 1'b1; flush = 1'b0; col_valid = 1'b0; state_ready = 1'b0;
        col_fwd = '0; col_inv = '0; col_raw = '0; mix_mode = '0; round_in = '0; rk_word = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col_ready", col_ready, 1'b0);
        chk("rst_valid", state_valid, 1'b0);
        chk("rst_out", state_out, 128'd0);
        chk("rst_round", state_round, 4'd0);
        chk("rst_last", state_last, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rel_ready_low", col_ready, 1'b0);
        @(posedge clk); #1;
        chk("rst_rel_ready_high", col_ready, 1'b1);

        // FIPS-197 App. B round 1, forward mode
        mf = '{32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
        mk = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
        mi = '{32'h0, 32'h0, 32'h0, 32'h0};
        mr = '{32'h0, 32'h0, 32'h0, 32'h0};
        mm = '{2'd0, 2'd0, 2'd0, 2'd0};
        mrd = '{4'd1, 4'd1, 4'd1, 4'd1};
        send_all("fips");
        check_state("fips");
        chk("fips_const", state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
`ifdef AES_ARK_PARITY_EN
        chk("fips_par_a4", state_par[15], 1'b1);
`endif

        // Backpressure with an upstream column waiting
        held = state_out;
        col_valid = 1'b1; col_fwd = 32'hdeadbeef; col_inv = 32'h12345678; col_raw = 32'h0;
        mix_mode = 2'd1; rk_word = 32'h55aa55aa; round_in = 4'd7;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            chk("bp_out_stable", state_out, held);
            chk("bp_col_ready", col_ready, 1'b0);
            chk("bp_valid", state_valid, 1'b1);
        end

        // Zero-bubble: take the held state while column 0 of the next enters
        mi = '{32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304};
        mk = '{32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304};
        mf = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
        mm = '{2'd1, 2'd0, 2'd2, 2'd0};
        mrd = '{4'd2, 4'd2, 4'd2, 4'd2};
        state_ready = 1'b1;
        send_idx(0);
        state_ready = 1'b0;
        chk("zb_valid_dropped", state_valid, 1'b0);
        c0 = cyc;
        for (int j = 1; j < 4; j++) send_idx(j);
        chk("zb_latency", cyc - c0, 3);
        check_state("inv");
        chk("inv_zero", state_out, 128'd0);
        take();

        // Raw mode, zero key
        mr = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
        mk = '{32'h0, 32'h0, 32'h0, 32'h0};
        mm = '{2'd2, 2'd2, 2'd2, 2'd2};
        send_all("raw");
        check_state("raw");
        chk("raw_ones", state_out, {128{1'b1}});
        take();

        // Round and mode latched on column 0 only
        randomize_table();
        mm  = '{2'd2, 2'd0, 2'd1, 2'd0};
        mrd = '{4'd10, 4'd10, 4'd3, 4'd10};
        send_all("latch");
        check_state("latch");
        chk("latch_round10", state_round, 4'd10);
        chk("latch_last", state_last, 1'b1);
        take();

        // Flush after two columns, with a column presented in the flush cycle
        randomize_table();
        send_idx(0);
        send_idx(1);
        col_valid = 1'b1; col_fwd = $urandom; col_inv = $urandom; col_raw = $urandom; rk_word = $urandom;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; col_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_no_valid", state_valid, 1'b0);
        end
        randomize_table();
        send_all("postflush");
        check_state("postflush");
        take();

        // Randomized states with random downstream stalls
        for (int t = 0; t < 12; t++) begin
            randomize_table();
            send_all("rnd");
            check_state("rnd");
            held = state_out;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk("rnd_stall_stable", state_out, held);
            end
            take();
        end

        // Asynchronous reset while a state is held
        randomize_table();
        send_all("pre_rst");
        check_state("pre_rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", state_valid, 1'b0);
        chk("arst_out", state_out, 128'd0);
        chk("arst_round", state_round, 4'd0);
        chk("arst_last", state_last, 1'b0);
        chk("arst_col_ready", col_ready, 1'b0);
`ifdef AES_ARK_PARITY_EN
        chk("arst_par", state_par, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_recover_ready", col_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ark_col_collect.md
Name: aes_ark_col_collect

Overview:
- Column-serial AddRoundKey and state assembler, directly downstream of the one-column MixColumns stage.
- Each accepted cycle takes one 32-bit column in one of three forms: forward-mixed (a0..a3), inverse-mixed (c0..c3), or unmixed (final round).
- XORs the selected column with the matching round-key word and packs four columns into a registered 128-bit state.
- Hands the state to the next round / output stage over a valid/ready handshake.

Parameters:
- ROUND_W, 4: width of the round tag carried with the state.
- LAST_ROUND, 10: round number that raises state_last (Nr; 12/14 for AES-192/256).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; discards partial and held state.
- col_valid  in  1  column present on inputs.
- col_ready  out  1  block can accept a column this cycle.
- col_fwd  in  32  forward MixColumns result, {a0,a1,a2,a3}, a0 in [31:24].
- col_inv  in  32  InvMixColumns result, {c0,c1,c2,c3}.
- col_raw  in  32  unmixed column {b0,b1,b2,b3}, used in the final round.
- mix_mode  in  2  0 = fwd, 1 = inv, 2 = raw, 3 = reserved (treated as raw).
- round_in  in  ROUND_W  round number of this state.
- rk_word  in  32  round-key word for the current column, aligned with col_valid.
- state_valid  out  1  state_out holds a complete state.
- state_ready  in  1  downstream accepts the state.
- state_out  out  128  assembled state; column 0 in [127:96].
- state_round  out  ROUND_W  latched round_in.
- state_last  out  1  state_round == LAST_ROUND.
- state_par  out  16  only with AES_ARK_PARITY_EN; see Optional Feature.

Behaviour:
- Reset: all outputs 0, except col_ready = 1 one cycle after rst deasserts. col_cnt = 0, FSM = COLLECT.
- A column is accepted when col_valid && col_ready.
- Column selection and key add: word = sel(mix_mode) ^ rk_word, written to column slot col_cnt.
- col_cnt counts 0..3 and wraps to 0 after slot 3.
- mix_mode and round_in are latched on column 0 only.
  - Values presented with columns 1..3 are ignored.
  - The latched mode applies to all four columns.
- FSM states:
  - COLLECT: col_ready = 1. On acceptance of slot 3, go to FULL next cycle with state_valid = 1.
  - FULL: state_out, state_round, state_last and state_par are held stable while state_valid && !state_ready.
  - FULL: col_ready = state_ready, so a new column 0 can be accepted in the same cycle the held state is taken (zero-bubble).
  - FULL, state_ready = 1, no new column: go to COLLECT with state_valid = 0.
  - FULL, state_ready = 1, column 0 accepted: go to COLLECT with col_cnt = 1.
- Throughput: one state per 4 cycles sustained. Latency: state_valid rises 1 cycle after the 4th column is accepted.
- Assembly uses a separate working register. state_out changes only on the COLLECT->FULL transition.
- flush (synchronous, highest priority):
  - col_cnt = 0, state_valid = 0, FSM = COLLECT, working register cleared.
  - Any column presented in the same cycle is dropped.
- Reset asserted mid-assembly: immediate return to the reset values; the partial state is lost.
- col_valid while col_ready = 0: no effect. The upstream stage holds its data.

Optional Feature:
- Macro: AES_ARK_PARITY_EN.
- Defined:
  - state_par[i] = XOR of state_out byte i (bit 15 = byte at [127:120]).
  - Registered with state_out and held under the same stall rules.
  - Reset value 0.
- Undefined: the state_par port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package aes_pkg holds:
  - AES_COL_W = 32, AES_STATE_W = 128, AES_NUM_COLS = 4.
  - Mode encodings MIX_FWD = 2'd0, MIX_INV = 2'd1, MIX_RAW = 2'd2.
  - FSM enum {COLLECT, FULL}.
- One sub-module, aes_ark_col_mux: combinational 3:1 column select plus XOR with rk_word, 32-bit.

Test Plan:
- FIPS-197 App. B, round 1, mode fwd:
  - Stimulus: col_fwd = 046681e5, e0cb199a, 48f8d37a, 2806264c; rk_word = a0fafe17, 88542cb1, 23a33939, 2a6c7605.
  - Required: state_out = a49c7ff2689f352b6b5bea43026a5049, state_last = 0, state_valid 1 cycle after the 4th column.
- Mode inv, col_inv = 01020304 and rk_word = 01020304 on all four columns -> state_out = 0. Mode raw, col_raw = ffffffff, rk = 0 -> state_out all-ones.
- round_in = 10 latched on column 0, changed to 3 on column 2 -> state_round = 10, state_last = 1. mix_mode changed mid-state -> ignored.
- Backpressure: state_ready = 0 for 5 cycles -> state_out stable and col_ready = 0. Then state_ready = 1 with column 0 valid -> both transfers occur in one cycle; next state_valid 4 cycles later.
- flush after 2 columns -> no state_valid. The next 4 columns produce a correct state from slot 0. Async rst mid-FULL -> all outputs 0 immediately.
- With AES_ARK_PARITY_EN, the FIPS state above -> state_par byte parities match the reference model (byte a4 -> 1). Macro undefined -> the design builds with the port absent.
